// File: rtl/bg_pixel_mixer.sv
// Background/sprite pixel mixer: pops the BG FIFO, drops fine-scroll pixels, merges the sprite
// candidate, applies DMG palettes and emits one shade per pixel with its framebuffer address.
module bg_pixel_mixer #(
  parameter int unsigned X_MAX = 160,
  parameter int unsigned Y_MAX = 144,
  parameter int unsigned FB_AW = 15
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             tclk_in,
  input  logic             line_start_in,
  input  logic [7:0]       Y_in,
  input  logic [7:0]       scx_in,
  output logic             bg_rd_en_out,
  input  logic [1:0]       bg_pixel_in,
  input  logic             bg_valid_in,
  input  logic [1:0]       sp_pixel_in,
  input  logic             sp_palette_in,
  input  logic             sp_priority_in,
  input  logic             sp_valid_in,
  input  logic             bg_ena_in,
  input  logic             obj_ena_in,
  input  logic [7:0]       bgp_in,
  input  logic [7:0]       obp0_in,
  input  logic [7:0]       obp1_in,
  output logic [7:0]       X_out,
  output logic [1:0]       pixel_out,
  output logic             pixel_valid_out,
  output logic [FB_AW-1:0] fb_addr_out,
  output logic             line_done_out
);

  typedef enum logic [1:0] {StIdle, StDiscard, StPush, StDone} state_e;

  state_e             r_state;
  logic [2:0]         r_disc;
  logic [FB_AW-1:0]   r_line_base;
  logic [7:0]         r_x;
  logic [1:0]         r_pixel;
  logic               r_valid;
  logic               r_done;
  logic [FB_AW-1:0]   r_fb_addr;

  logic               w_line_start;
  logic [1:0]         w_bi;
  logic               w_sp_win;
  logic [7:0]         w_pal;
  logic [1:0]         w_idx;
  logic [1:0]         w_shade;
  logic               w_last;
  logic [4:0]         w_unused_scx;

  assign w_unused_scx = scx_in[7:3];

  // Off-screen line starts (vblank lines) are ignored entirely.
  assign w_line_start = line_start_in && (32'(Y_in) < Y_MAX);

  assign w_bi     = bg_ena_in ? bg_pixel_in : 2'd0;
  assign w_sp_win = obj_ena_in && sp_valid_in && (sp_pixel_in != 2'd0) &&
                    !(sp_priority_in && (w_bi != 2'd0));
  assign w_pal    = w_sp_win ? (sp_palette_in ? obp1_in : obp0_in) : bgp_in;
  assign w_idx    = w_sp_win ? sp_pixel_in : w_bi;
  assign w_last   = (r_x == 8'(X_MAX - 1));

  always_comb begin
    w_shade = 2'd0;
    case (w_idx)
      2'd0:    w_shade = w_pal[1:0];
      2'd1:    w_shade = w_pal[3:2];
      2'd2:    w_shade = w_pal[5:4];
      default: w_shade = w_pal[7:6];
    endcase
  end

  assign bg_rd_en_out = tclk_in && ((r_state == StDiscard) || (r_state == StPush));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= StIdle;
      r_disc      <= 3'd0;
      r_line_base <= '0;
      r_x         <= 8'd0;
      r_pixel     <= 2'd0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_fb_addr   <= '0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      if (w_line_start) begin
        r_disc      <= scx_in[2:0];
        r_line_base <= FB_AW'(Y_in) * FB_AW'(X_MAX);
        r_x         <= 8'd0;
        r_state     <= (scx_in[2:0] != 3'd0) ? StDiscard : StPush;
      end else if (bg_valid_in) begin
        case (r_state)
          StDiscard: begin
            r_disc <= r_disc - 3'd1;
            if (r_disc == 3'd1) r_state <= StPush;
          end
          StPush: begin
            r_valid   <= 1'b1;
            r_pixel   <= w_shade;
            r_fb_addr <= r_line_base + FB_AW'(r_x);
            r_x       <= r_x + 8'd1;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign X_out           = r_x;
  assign pixel_out       = r_pixel;
  assign pixel_valid_out = r_valid;
  assign fb_addr_out     = r_fb_addr;
  assign line_done_out   = r_done;

endmodule

// File: tb/tb_bg_pixel_mixer.sv
// Randomized scoreboard bench for bg_pixel_mixer: a counting reference model queues expected
// pixels per pop, and a negedge monitor pops and compares whenever pixel_valid_out is high.
module tb_bg_pixel_mixer;
  localparam int unsigned XM = 160;
  localparam int unsigned YM = 144;
  localparam int unsigned AW = 15;

  logic          clk_in = 1'b0;
  logic          rst_in, tclk_in, line_start_in;
  logic [7:0]    Y_in, scx_in;
  logic          bg_rd_en_out;
  logic [1:0]    bg_pixel_in;
  logic          bg_valid_in;
  logic [1:0]    sp_pixel_in;
  logic          sp_palette_in, sp_priority_in, sp_valid_in;
  logic          bg_ena_in, obj_ena_in;
  logic [7:0]    bgp_in, obp0_in, obp1_in;
  logic [7:0]    X_out;
  logic [1:0]    pixel_out;
  logic          pixel_valid_out;
  logic [AW-1:0] fb_addr_out;
  logic          line_done_out;

  logic gate, force_valid;
  assign bg_valid_in = (bg_rd_en_out & gate) | force_valid;

  bg_pixel_mixer #(.X_MAX(XM), .Y_MAX(YM), .FB_AW(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tclk_in(tclk_in), .line_start_in(line_start_in),
    .Y_in(Y_in), .scx_in(scx_in), .bg_rd_en_out(bg_rd_en_out), .bg_pixel_in(bg_pixel_in),
    .bg_valid_in(bg_valid_in), .sp_pixel_in(sp_pixel_in), .sp_palette_in(sp_palette_in),
    .sp_priority_in(sp_priority_in), .sp_valid_in(sp_valid_in), .bg_ena_in(bg_ena_in),
    .obj_ena_in(obj_ena_in), .bgp_in(bgp_in), .obp0_in(obp0_in), .obp1_in(obp1_in),
    .X_out(X_out), .pixel_out(pixel_out), .pixel_valid_out(pixel_valid_out),
    .fb_addr_out(fb_addr_out), .line_done_out(line_done_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0]  shade;
    logic [14:0] addr;
    logic [7:0]  x;
    logic        done;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: line in progress, pops seen this line, fine-scroll count, line base.
  bit   m_active = 1'b0;
  int   m_pops = 0;
  int   m_disc = 0;
  int   m_base = 0;
  int   mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_shade(input int bg, input int bgena, input int sp,
                                           input int spv, input int spal, input int prio,
                                           input int objena, input int bgp, input int obp0,
                                           input int obp1);
    int bi, pal, idx;
    bit win;
    bi  = (bgena != 0) ? bg : 0;
    win = (objena != 0) && (spv != 0) && (sp != 0) && !((prio != 0) && (bi != 0));
    pal = win ? ((spal != 0) ? obp1 : obp0) : bgp;
    idx = win ? sp : bi;
    return 2'((pal >> (2 * idx)) & 3);
  endfunction

  task automatic model_pop();
    exp_t e;
    int   x;
    if (m_pops >= m_disc) begin
      x = m_pops - m_disc;
      e.shade = ref_shade(int'(bg_pixel_in), int'(bg_ena_in), int'(sp_pixel_in),
                          int'(sp_valid_in), int'(sp_palette_in), int'(sp_priority_in),
                          int'(obj_ena_in), int'(bgp_in), int'(obp0_in), int'(obp1_in));
      e.addr  = 15'((m_base + x) % (1 << AW));
      e.x     = 8'(x + 1);
      e.done  = (x == XM - 1);
      sbq.push_back(e);
      if (x == XM - 1) m_active = 1'b0;
    end
    m_pops++;
  endtask

  task automatic drive_data();
    int k;
    case (mode)
      0: begin
        bg_pixel_in = 2'(m_pops % 4);
        sp_pixel_in = 2'd0; sp_palette_in = 1'b0; sp_priority_in = 1'b0; sp_valid_in = 1'b0;
        bg_ena_in = 1'b1; obj_ena_in = 1'b1; bgp_in = 8'hE4; obp0_in = 8'h1B; obp1_in = 8'hD2;
      end
      1: begin
        bg_pixel_in = 2'($urandom); sp_pixel_in = 2'($urandom);
        sp_palette_in = 1'($urandom); sp_priority_in = 1'($urandom);
        sp_valid_in = 1'($urandom); bg_ena_in = ($urandom_range(0, 3) != 0);
        obj_ena_in = ($urandom_range(0, 3) != 0);
        bgp_in = 8'($urandom); obp0_in = 8'($urandom); obp1_in = 8'($urandom);
      end
      default: begin
        k = m_pops % 6;
        bgp_in = 8'hE4; obp0_in = 8'h1B; obp1_in = 8'hD2;
        bg_ena_in = 1'b1; obj_ena_in = 1'b1; sp_valid_in = 1'b1;
        sp_palette_in = 1'b0; sp_priority_in = 1'b0;
        case (k)
          0: begin bg_pixel_in = 2'd2; sp_pixel_in = 2'd1; end
          1: begin bg_pixel_in = 2'd2; sp_pixel_in = 2'd1; sp_priority_in = 1'b1; end
          2: begin
            bg_pixel_in = 2'd0; sp_pixel_in = 2'd3; sp_palette_in = 1'b1; sp_priority_in = 1'b1;
          end
          3: begin bg_pixel_in = 2'd1; sp_pixel_in = 2'd0; end
          4: begin bg_pixel_in = 2'd3; sp_pixel_in = 2'd0; sp_valid_in = 1'b0; bg_ena_in = 1'b0; end
          default: begin bg_pixel_in = 2'd1; sp_pixel_in = 2'd3; obj_ena_in = 1'b0; end
        endcase
      end
    endcase
  endtask

  // One clock: drive at negedge, update the model for the coming posedge, return at next negedge.
  task automatic cyc(input logic ls, input logic [7:0] y, input logic [7:0] scx,
                     input logic rst, input logic fv);
    rst_in = rst; line_start_in = ls; Y_in = y; scx_in = scx; force_valid = fv;
    tclk_in = ($urandom_range(0, 3) != 0);
    gate = (ls || rst) ? 1'b0 : ($urandom_range(0, 4) != 0);
    drive_data();
    #1;
    if (!rst) check("bg_rd_en", 32'(bg_rd_en_out), 32'(tclk_in && m_active));
    if (rst) begin
      m_active = 1'b0;
      sbq.delete();
    end else if (ls && (int'(y) < YM)) begin
      m_active = 1'b1;
      m_pops = 0;
      m_disc = int'(scx) % 8;
      m_base = (int'(y) * XM) % (1 << AW);
    end else if (bg_valid_in && m_active) begin
      model_pop();
    end
    @(negedge clk_in);
  endtask

  task automatic run_line(input logic [7:0] y, input logic [7:0] scx);
    int n;
    cyc(1'b1, y, scx, 1'b0, 1'b0);
    n = 0;
    while (m_active && n < 3000) begin
      cyc(1'b0, y, scx, 1'b0, 1'b0);
      n++;
    end
    if (m_active) begin
      n_chk++; n_fail++;
      $display("FAIL line_timeout: line %0d still active after %0d cycles", y, n);
      m_active = 1'b0;
    end
    cyc(1'b0, y, scx, 1'b0, 1'b0);
    check("done_x_hold", 32'(X_out), 32'(XM));
    check("queue_drained", 32'(sbq.size()), 32'd0);
  endtask

  always @(negedge clk_in) begin
    if (pixel_valid_out === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pixel: got addr %0d with no expected pixel", fb_addr_out);
      end else begin
        mon_e = sbq.pop_front();
        check("shade", 32'(pixel_out), 32'(mon_e.shade));
        check("fb_addr", 32'(fb_addr_out), 32'(mon_e.addr));
        check("x_out", 32'(X_out), 32'(mon_e.x));
        check("line_done", 32'(line_done_out), 32'(mon_e.done));
      end
    end else if (line_done_out === 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL stray_line_done: got 1 expected 0 without pixel_valid_out");
    end
  end

  initial begin
    int n;
    rst_in = 1'b1; tclk_in = 1'b0; line_start_in = 1'b0; Y_in = 8'd0; scx_in = 8'd0;
    gate = 1'b0; force_valid = 1'b0;
    mode = 0;
    drive_data();

    cyc(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    check("rst_x", 32'(X_out), 32'd0);
    check("rst_pixel", 32'(pixel_out), 32'd0);
    check("rst_valid", 32'(pixel_valid_out), 32'd0);
    check("rst_fb_addr", 32'(fb_addr_out), 32'd0);
    check("rst_line_done", 32'(line_done_out), 32'd0);
    repeat (3) cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);

    mode = 0;
    run_line(8'd0, 8'd0);
    repeat (4) cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    run_line(8'd2, 8'h05);
    mode = 2;
    run_line(8'd10, 8'h00);
    run_line(8'd143, 8'hFB);
    mode = 1;
    repeat (4) run_line(8'($urandom_range(0, YM - 1)), 8'($urandom));

    // Off-screen line start while DONE must not restart anything.
    cyc(1'b1, 8'd200, 8'd0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 8'd200, 8'd0, 1'b0, 1'b0);
    check("offscreen_ignored_x", 32'(X_out), 32'(XM));

    // Abort line 5 after 50 pixels, restart on line 9 with fine scroll 3.
    mode = 0;
    cyc(1'b1, 8'd5, 8'd0, 1'b0, 1'b0);
    n = 0;
    while (m_pops < 50 && n < 1000) begin
      cyc(1'b0, 8'd5, 8'd0, 1'b0, 1'b0);
      n++;
    end
    check("abort_progress", 32'(X_out >= 8'd40), 32'd1);
    run_line(8'd9, 8'd3);

    // Reset in the middle of a line.
    mode = 1;
    cyc(1'b1, 8'd20, 8'd0, 1'b0, 1'b0);
    repeat (30) cyc(1'b0, 8'd20, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, 8'd20, 8'd0, 1'b1, 1'b0);
    check("midrst_x", 32'(X_out), 32'd0);
    check("midrst_valid", 32'(pixel_valid_out), 32'd0);
    check("midrst_fb_addr", 32'(fb_addr_out), 32'd0);
    check("midrst_pixel", 32'(pixel_out), 32'd0);
    repeat (5) cyc(1'b0, 8'd20, 8'd0, 1'b0, 1'b1);
    check("midrst_idle_x", 32'(X_out), 32'd0);
    run_line(8'd21, 8'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bg_pixel_mixer.md
Name: bg_pixel_mixer

Overview:
Downstream consumer of the background pixel FIFO in the PPU pixel pipeline. Per scanline it pops background pixels and discards the first SCX[2:0] of them (fine scroll). It merges each remaining pixel with the sprite candidate pixel, applies the DMG palettes, and emits one 2-bit shade per pixel with a linear framebuffer address. It tracks the on-screen X position and signals end-of-line to the PPU mode controller.

Parameters:
X_MAX, 160, visible pixels per line
Y_MAX, 144, visible lines
FB_AW, 15, framebuffer address width (must satisfy 2^FB_AW >= X_MAX*Y_MAX)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
tclk_in  in  1  T-cycle enable, one clk_in wide
line_start_in  in  1  pulse at start of mode 3 for the current line
Y_in  in  8  current scanline, sampled on line_start_in
scx_in  in  8  SCX register, sampled on line_start_in
bg_rd_en_out  out  1  pop request to background FIFO
bg_pixel_in  in  2  background colour index
bg_valid_in  in  1  bg_pixel_in valid this clk
sp_pixel_in  in  2  sprite colour index (0 = transparent)
sp_palette_in  in  1  0 = OBP0, 1 = OBP1
sp_priority_in  in  1  1 = sprite behind BG colours 1-3
sp_valid_in  in  1  sprite fields valid, qualified by bg_valid_in
bg_ena_in  in  1  LCDC.0
obj_ena_in  in  1  LCDC.1
bgp_in  in  8  BGP
obp0_in  in  8  OBP0
obp1_in  in  8  OBP1
X_out  out  8  pixels emitted so far this line
pixel_out  out  2  final shade
pixel_valid_out  out  1  pixel_out / fb_addr_out valid
fb_addr_out  out  FB_AW  Y*X_MAX + X of pixel_out
line_done_out  out  1  one-clk pulse, coincident with last pixel of line

Behaviour:
- Reset (synchronous, rst_in high at posedge clk_in): state=IDLE, X_out=0, pixel_out=0, pixel_valid_out=0, fb_addr_out=0, line_done_out=0, discard counter=0. Reset overrides everything, including mid-line.
- States: IDLE, DISCARD, PUSH, DONE.
- line_start_in with Y_in < Y_MAX, in any state:
  - Latch disc = scx_in[2:0] and line_base = Y_in*X_MAX, computed with FB_AW-bit arithmetic. Set X=0.
  - Next state is DISCARD if disc != 0, else PUSH. This aborts any line in progress; a pixel already in the output register still presents on the following clk.
- line_start_in with Y_in >= Y_MAX is ignored.
- bg_rd_en_out = tclk_in && (state==DISCARD || state==PUSH). It is combinational and never asserted in IDLE or DONE.
- DISCARD: each bg_valid_in decrements disc and produces no output. When a pop arrives with disc==1, the next state is PUSH.
- PUSH: each bg_valid_in produces one output pixel after exactly one clk of latency (registered outputs).
  - bi = bg_ena_in ? bg_pixel_in : 0.
  - The sprite wins iff obj_ena_in && sp_valid_in && sp_pixel_in != 0 && !(sp_priority_in && bi != 0).
  - If the sprite wins: pal = sp_palette_in ? obp1_in : obp0_in, idx = sp_pixel_in. Otherwise pal = bgp_in, idx = bi.
  - pixel_out = pal[2*idx+1 : 2*idx]. fb_addr_out = line_base + X. X_out increments by 1.
  - If the popped pixel is pixel X_MAX-1: line_done_out=1 in the same clk as that pixel's pixel_valid_out, and the next state is DONE.
- pixel_valid_out and line_done_out are single-clk pulses and are 0 whenever no pixel is produced.
- DONE: no pops. Holds X_out=X_MAX until the next line_start_in.
- bg_valid_in outside DISCARD/PUSH is ignored. Sprite inputs are ignored unless bg_valid_in is also high.
- X_out never exceeds X_MAX. fb_addr_out never exceeds X_MAX*Y_MAX-1.
- Palette and enable inputs are sampled in the clk of each pop, not latched per line.

Test Plan:
- SCX=0, Y=0, BGP=0xE4, bg index ramp 0,1,2,3 repeating -> first pixel 1 clk after first pop, shades 0,1,2,3, fb_addr 0..159, line_done pulse with pixel 159, then no further pops.
- SCX=0x05, Y=2 -> first 5 pops produce no pixel_valid_out; 6th pop emits fb_addr 320; 160 pixels total.
- BGP=0xE4, OBP0=0x1B, OBP1=0xD2, obj_ena=1:
  - bg=2, sp=1 palette 0 prio 0 -> shade 2.
  - bg=2, sp=1 prio 1 -> shade 2 via BGP.
  - bg=0, sp=3 palette 1 prio 1 -> shade 3.
  - sp=0 -> shade from BGP.
- bg_ena=0 with bg=3, no sprite -> shade BGP[1:0]. obj_ena=0 with a non-transparent sprite -> BG shade.
- line_start_in asserted after 50 pixels of line 5 -> X_out returns to 0, next pixel fb_addr=Y_new*160, no line_done for the aborted line.
- rst_in high mid-PUSH -> next clk: state IDLE, bg_rd_en_out=0, all outputs 0. Pops are ignored until line_start_in.
